// File: rtl/mac_accumulate_stage8.sv
// mac_accumulate_stage8
//   Burst multiply-accumulate controller wrapped around an external combinational
//   OP_W x OP_W unsigned multiplier. Operand pairs arrive over a valid/ready
//   handshake, are registered onto mul_op*_o, and the returned product is folded
//   into the accumulator one cycle later. The dot-product sum is presented on a
//   valid/ready output.
//   Build option: define SATURATE_EN to clamp the accumulator on carry-out
//   instead of wrapping modulo 2^ACC_W.
//
//   state | meaning
//   IDLE  | waiting for start_i
//   RUN   | accepting operand pairs, one per cycle
//   DRAIN | folding the last pending product into the accumulator
//   DONE  | result held on acc_o / ovf_o until acc_ready_i
module mac_accumulate_stage8 #(
  parameter int OP_W   = 8,
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OP_W-1:0]   op1_i,
  input  logic [OP_W-1:0]   op2_i,
  output logic [OP_W-1:0]   mul_op1_o,
  output logic [OP_W-1:0]   mul_op2_o,
  input  logic [PROD_W-1:0] mul_product_i,
  output logic              acc_valid_o,
  input  logic              acc_ready_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              ovf_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic             pending;
  logic [LEN_W-1:0] remaining;
  logic             accept;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;

  // in_ready_o is registered and only ever high in RUN, so it doubles as the state gate
  assign accept = in_valid_i && in_ready_o;

  // One extra bit catches the carry out of the accumulator
  assign sum = {1'b0, acc_o} + {{(ACC_W + 1 - PROD_W){1'b0}}, mul_product_i};

`ifdef SATURATE_EN
  // Once clamped at all-ones, any further nonzero product carries again, so the clamp holds
  assign acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  // Control FSM, operand registers and accumulator; all outputs registered
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      pending     <= 1'b0;
      remaining   <= '0;
      acc_o       <= '0;
      ovf_o       <= 1'b0;
      mul_op1_o   <= '0;
      mul_op2_o   <= '0;
      acc_valid_o <= 1'b0;
      in_ready_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      // The product of the pair accepted last cycle is on mul_product_i now
      if (pending) begin
        acc_o   <= acc_next;
        pending <= 1'b0;
        if (sum[ACC_W]) ovf_o <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            remaining <= len_i;
            acc_o     <= '0;
            ovf_o     <= 1'b0;
            busy_o    <= 1'b1;
            if (len_i == '0) begin
              state       <= DONE;
              acc_valid_o <= 1'b1;
            end else begin
              state      <= RUN;
              in_ready_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            mul_op1_o <= op1_i;
            mul_op2_o <= op2_i;
            pending   <= 1'b1;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state      <= DRAIN;
              in_ready_o <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Wait one cycle for the final product to land before raising valid
          if (!pending) begin
            state       <= DONE;
            acc_valid_o <= 1'b1;
          end
        end
        DONE: begin
          if (acc_ready_i) begin
            state       <= IDLE;
            acc_valid_o <= 1'b0;
            busy_o      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
